// File: rtl/cpu_mc_pkg.sv
// Shared types and encodings for the multi-cycle core: FSM states, opcodes,
// ALU operations and immediate formats.
package cpu_mc_pkg;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_HALT
  } state_t;

  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_LD    = 7'b0000011;
  localparam logic [6:0] OP_SD    = 7'b0100011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_ECALL = 7'b1110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_SUB  = 7'b0100000;
  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_AND  = 3'b111;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_BEQ  = 3'b000;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_NONE
  } alu_op_t;

  typedef enum logic [1:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_B
  } imm_fmt_t;

  function automatic imm_fmt_t imm_fmt_of(input logic [6:0] opcode);
    imm_fmt_t fmt;
    case (opcode)
      OP_LD, OP_ITYPE: fmt = IMM_I;
      OP_SD:           fmt = IMM_S;
      OP_BEQ:          fmt = IMM_B;
      default:         fmt = IMM_NONE;
    endcase
    return fmt;
  endfunction

  function automatic alu_op_t rtype_op(input logic [6:0] f7, input logic [2:0] f3);
    alu_op_t op;
    op = ALU_NONE;
    if (f7 == F7_BASE && f3 == F3_ADD) op = ALU_ADD;
    if (f7 == F7_SUB  && f3 == F3_ADD) op = ALU_SUB;
    if (f7 == F7_BASE && f3 == F3_AND) op = ALU_AND;
    if (f7 == F7_BASE && f3 == F3_OR)  op = ALU_OR;
    return op;
  endfunction

  function automatic alu_op_t itype_op(input logic [2:0] f3);
    alu_op_t op;
    case (f3)
      F3_ADD:  op = ALU_ADD;
      F3_AND:  op = ALU_AND;
      F3_OR:   op = ALU_OR;
      default: op = ALU_NONE;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/cpu_mc_regfile.sv
// Register file: NREG x XLEN, two asynchronous read ports, one synchronous
// write port, x0 hard-wired to zero, asynchronous active-low clear.
module cpu_mc_regfile
  import cpu_mc_pkg::*;
#(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned NREG  = 32,
  parameter int unsigned IDX_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] raddr1,
  input  logic [IDX_W-1:0] raddr2,
  output logic [XLEN-1:0]  rdata1,
  output logic [XLEN-1:0]  rdata2,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [XLEN-1:0]  wdata
);

  logic [XLEN-1:0] regs [NREG];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (we && waddr != '0) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata1 = (raddr1 == '0) ? '0 : regs[raddr1];
  assign rdata2 = (raddr2 == '0) ? '0 : regs[raddr2];

endmodule

// File: rtl/cpu_multicycle.sv
// Multi-cycle RV64I-subset core over one shared req/ack memory port.
// Define CPU_MC_ITYPE_EN to enable addi/andi/ori (opcode 0010011).
module cpu_multicycle
  import cpu_mc_pkg::*;
#(
  parameter int unsigned XLEN     = 64,
  parameter int unsigned NREG     = 32,
  parameter int unsigned ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic [XLEN-1:0]   mem_rdata,
  input  logic              mem_ack,
  output logic [ADDR_W-1:0] pc,
  output logic              halted,
  output logic              illegal
);

  localparam int unsigned RIDX_W = (NREG > 1) ? $clog2(NREG) : 1;

  state_t state, next_state;

  logic [31:0]      ir;
  logic [XLEN-1:0]  a, b, imm, aluout, mdr;
  logic [XLEN-1:0]  imm_dec, alu_b, alu_res;
  logic [XLEN-1:0]  rf_rd1, rf_rd2, rf_wdata;
  logic [ADDR_W-1:0] pc_d, pc_plus4, pc_branch;
  logic             accept, is_store, rf_we;
  alu_op_t          alu_op;
  state_t           exec_target;
  logic             exec_illegal;

  logic              req_d, we_d;
  logic [ADDR_W-1:0] addr_d;
  logic [XLEN-1:0]   wdata_d;

  logic [6:0] opcode, f7;
  logic [2:0] f3;
  logic [RIDX_W-1:0] rs1, rs2, rd;

  assign opcode   = ir[6:0];
  assign f3       = ir[14:12];
  assign f7       = ir[31:25];
  assign rs1      = ir[15 +: RIDX_W];
  assign rs2      = ir[20 +: RIDX_W];
  assign rd       = ir[7 +: RIDX_W];
  assign accept   = mem_req & mem_ack;
  assign is_store = (opcode == OP_SD);
  assign halted   = (state == ST_HALT);

  cpu_mc_regfile #(
    .XLEN  (XLEN),
    .NREG  (NREG),
    .IDX_W (RIDX_W)
  ) u_rf (
    .clk    (clk),
    .rst_n  (reset),
    .raddr1 (rs1),
    .raddr2 (rs2),
    .rdata1 (rf_rd1),
    .rdata2 (rf_rd2),
    .we     (rf_we),
    .waddr  (rd),
    .wdata  (rf_wdata)
  );

  assign rf_we    = (state == ST_WB);
  assign rf_wdata = (opcode == OP_LD) ? mdr : aluout;

  always_comb begin
    imm_dec = '0;
    case (imm_fmt_of(opcode))
      IMM_I:   imm_dec = {{(XLEN-12){ir[31]}}, ir[31:20]};
      IMM_S:   imm_dec = {{(XLEN-12){ir[31]}}, ir[31:25], ir[11:7]};
      IMM_B:   imm_dec = {{(XLEN-13){ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
      default: imm_dec = '0;
    endcase
  end

  // Instruction classification used in EXEC: ALU operation, successor state
  // and whether an unsupported encoding stops the core.
  always_comb begin
    alu_op       = ALU_ADD;
    alu_b        = imm;
    exec_target  = ST_HALT;
    exec_illegal = 1'b1;
    case (opcode)
      OP_RTYPE: begin
        alu_op = rtype_op(f7, f3);
        alu_b  = b;
        if (alu_op != ALU_NONE) begin
          exec_target  = ST_WB;
          exec_illegal = 1'b0;
        end
      end
      OP_LD, OP_SD: begin
        exec_target  = ST_MEM;
        exec_illegal = 1'b0;
      end
      OP_BEQ: begin
        if (f3 == F3_BEQ) begin
          exec_target  = ST_FETCH;
          exec_illegal = 1'b0;
        end
      end
      OP_ECALL: begin
        exec_target  = ST_HALT;
        exec_illegal = 1'b0;
      end
`ifdef CPU_MC_ITYPE_EN
      OP_ITYPE: begin
        alu_op = itype_op(f3);
        if (alu_op != ALU_NONE) begin
          exec_target  = ST_WB;
          exec_illegal = 1'b0;
        end
      end
`endif
      default: ;
    endcase
  end

  always_comb begin
    case (alu_op)
      ALU_SUB: alu_res = a - alu_b;
      ALU_AND: alu_res = a & alu_b;
      ALU_OR:  alu_res = a | alu_b;
      default: alu_res = a + alu_b;
    endcase
  end

  assign pc_plus4  = pc + ADDR_W'(4);
  assign pc_branch = pc + imm[ADDR_W-1:0];

  always_comb begin
    pc_d = pc;
    case (state)
      ST_EXEC: if (opcode == OP_BEQ && exec_target == ST_FETCH)
                 pc_d = (a == b) ? pc_branch : pc_plus4;
      ST_MEM:  if (accept && is_store) pc_d = pc_plus4;
      ST_WB:   pc_d = pc_plus4;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_FETCH;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_FETCH:  if (accept) next_state = ST_DECODE;
      ST_DECODE: next_state = ST_EXEC;
      ST_EXEC:   next_state = exec_target;
      ST_MEM:    if (accept) next_state = is_store ? ST_FETCH : ST_WB;
      ST_WB:     next_state = ST_FETCH;
      default:   next_state = ST_HALT;
    endcase
  end

  // Memory outputs are registered: a pending request holds until acked, and the
  // following request is launched at the same edge that enters FETCH or MEM.
  // After reset FETCH starts with mem_req low, so the first fetch is issued here.
  always_comb begin
    req_d   = mem_req;
    we_d    = mem_we;
    addr_d  = mem_addr;
    wdata_d = mem_wdata;
    if (!mem_req || mem_ack) begin
      req_d = 1'b0;
      we_d  = 1'b0;
      if (next_state == ST_FETCH) begin
        req_d  = 1'b1;
        addr_d = pc_d;
      end else if (next_state == ST_MEM) begin
        req_d  = 1'b1;
        we_d   = is_store;
        addr_d = alu_res[ADDR_W-1:0];
        if (is_store) wdata_d = b;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_req   <= req_d;
      mem_we    <= we_d;
      mem_addr  <= addr_d;
      mem_wdata <= wdata_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc      <= RESET_PC;
      ir      <= '0;
      a       <= '0;
      b       <= '0;
      imm     <= '0;
      aluout  <= '0;
      mdr     <= '0;
      illegal <= 1'b0;
    end else begin
      pc <= pc_d;
      case (state)
        ST_FETCH: if (accept) ir <= mem_rdata[31:0];
        ST_DECODE: begin
          a   <= rf_rd1;
          b   <= rf_rd2;
          imm <= imm_dec;
        end
        ST_EXEC: begin
          aluout <= alu_res;
          if (exec_target == ST_HALT) illegal <= exec_illegal;
        end
        ST_MEM: if (accept && !is_store) mdr <= mem_rdata;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_multicycle.sv
// Self-checking bench for cpu_multicycle: behavioural memory with configurable
// ack latency and a scoreboard of expected stores.
module tb_cpu_multicycle;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, pc;
  logic [63:0] mem_wdata, mem_rdata;
  logic        halted, illegal;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int unsigned wait_cyc = 0;

  logic [63:0] mem [longint unsigned];

  typedef struct {
    logic [31:0] addr;
    logic [63:0] data;
  } wr_t;
  wr_t         exp_wr[$];
  logic [31:0] rd_addr_log[$];
  int          rd_cyc_log[$];

  cpu_multicycle #(
    .XLEN     (64),
    .NREG     (32),
    .ADDR_W   (32),
    .RESET_PC (32'h0)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .pc        (pc),
    .halted    (halted),
    .illegal   (illegal)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // Memory: decides ack on the falling edge so the DUT samples it on the next rising edge.
  initial begin : mem_model
    int unsigned cnt;
    bit          pend;
    logic [31:0] pa;
    logic        pw;
    logic [63:0] pd;
    wr_t         e;
    cnt = 0;
    pend = 0;
    mem_ack = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      cyc++;
      mem_ack = 1'b0;
      if (mem_req) begin
        if (pend) begin
          checks++;
          if (mem_addr !== pa || mem_we !== pw || (pw && mem_wdata !== pd)) begin
            errors++;
            $display("FAIL req_stable addr %h we %b got, held addr %h we %b required", mem_addr, mem_we, pa, pw);
          end
        end else begin
          pend = 1;
          pa = mem_addr;
          pw = mem_we;
          pd = mem_wdata;
        end
        if (cnt == wait_cyc) begin
          cnt = 0;
          pend = 0;
          mem_ack = 1'b1;
          if (mem_we) begin
            mem[mem_addr] = mem_wdata;
            checks++;
            if (exp_wr.size() == 0) begin
              errors++;
              $display("FAIL store_unexpected addr %h data %h, no store required", mem_addr, mem_wdata);
            end else begin
              e = exp_wr.pop_front();
              if (mem_addr !== e.addr || mem_wdata !== e.data) begin
                errors++;
                $display("FAIL store addr %h data %h, required addr %h data %h", mem_addr, mem_wdata, e.addr, e.data);
              end
            end
          end else begin
            mem_rdata = mem.exists(longint'(mem_addr)) ? mem[longint'(mem_addr)] : '0;
            rd_addr_log.push_back(mem_addr);
            rd_cyc_log.push_back(cyc);
          end
        end else begin
          cnt++;
        end
      end else begin
        cnt = 0;
        pend = 0;
      end
    end
  end

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input int rs2, input int rs1,
                                        input logic [2:0] f3, input int rd);
    return {f7, 5'(rs2), 5'(rs1), f3, 5'(rd), 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_i(input int imm, input int rs1, input logic [2:0] f3,
                                        input int rd, input logic [6:0] op);
    logic [11:0] i;
    i = imm[11:0];
    return {i, 5'(rs1), f3, 5'(rd), op};
  endfunction

  function automatic logic [31:0] enc_ld(input int rd, input int imm, input int rs1);
    return enc_i(imm, rs1, 3'b011, rd, 7'b0000011);
  endfunction

  function automatic logic [31:0] enc_sd(input int rs2, input int imm, input int rs1);
    logic [11:0] i;
    i = imm[11:0];
    return {i[11:5], 5'(rs2), 5'(rs1), 3'b011, i[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] enc_b(input int rs1, input int rs2, input int imm, input logic [2:0] f3);
    logic [12:0] i;
    i = imm[12:0];
    return {i[12], i[10:5], 5'(rs2), 5'(rs1), f3, i[4:1], i[11], 7'b1100011};
  endfunction

  localparam logic [31:0] ECALL = 32'h0000_0073;

  function automatic int find_rd(input logic [31:0] a);
    foreach (rd_addr_log[i]) if (rd_addr_log[i] == a) return rd_cyc_log[i];
    return -100000;
  endfunction

  task automatic put(input logic [31:0] a, input logic [63:0] w);
    mem[longint'(a)] = w;
  endtask

  task automatic hold_reset();
    reset = 1'b0;
    @(negedge clk);
    mem.delete();
    exp_wr.delete();
    rd_addr_log.delete();
    rd_cyc_log.delete();
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic wait_halt(input int max, output bit ok);
    ok = 0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (halted) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic chk_halt(input string name, input bit ok, input bit exp_illegal);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s_halt timeout, halted=%b required 1", name, halted);
    end
    checks++;
    if (illegal !== exp_illegal) begin
      errors++;
      $display("FAIL %s_illegal got %b required %b", name, illegal, exp_illegal);
    end
  endtask

  task automatic chk_drained(input string name);
    checks++;
    if (exp_wr.size() != 0) begin
      errors++;
      $display("FAIL %s_stores %0d stores still outstanding, required 0", name, exp_wr.size());
    end
  endtask

  task automatic test_reset();
    bit seen;
    #2 reset = 1'b0;
    repeat (2) @(negedge clk);
    checks += 7;
    if (mem_req !== 1'b0)    begin errors++; $display("FAIL rst_req got %b required 0", mem_req); end
    if (mem_we !== 1'b0)     begin errors++; $display("FAIL rst_we got %b required 0", mem_we); end
    if (mem_addr !== '0)     begin errors++; $display("FAIL rst_addr got %h required 0", mem_addr); end
    if (mem_wdata !== '0)    begin errors++; $display("FAIL rst_wdata got %h required 0", mem_wdata); end
    if (halted !== 1'b0)     begin errors++; $display("FAIL rst_halted got %b required 0", halted); end
    if (illegal !== 1'b0)    begin errors++; $display("FAIL rst_illegal got %b required 0", illegal); end
    if (pc !== 32'h0)        begin errors++; $display("FAIL rst_pc got %h required 0", pc); end
    put(0, {32'h0, ECALL});
    release_reset();
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      #1 seen = (rd_addr_log.size() > 0);
    end
    checks++;
    if (!seen || rd_addr_log[0] !== 32'h0) begin
      errors++;
      $display("FAIL rst_first_fetch seen %b addr %h required 1 / 00000000", seen, seen ? rd_addr_log[0] : 32'hx);
    end
  endtask

  task automatic test_add();
    bit ok;
    int d;
    hold_reset();
    wait_cyc = 0;
    put(32'h100, 64'd5);
    put(32'h108, 64'd7);
    put(0,  {32'h0, enc_ld(1, 32'h100, 0)});
    put(4,  {32'h0, enc_ld(2, 32'h108, 0)});
    put(8,  {32'h0, 32'h002081B3});
    put(12, {32'h0, enc_sd(3, 32'h110, 0)});
    put(16, {32'h0, ECALL});
    exp_wr.push_back('{32'h110, 64'd12});
    release_reset();
    wait_halt(200, ok);
    chk_halt("add", ok, 1'b0);
    d = find_rd(12) - find_rd(8);
    checks++;
    if (d != 4) begin errors++; $display("FAIL add_cycles got %0d required 4", d); end
    checks++;
    if (pc !== 32'd16) begin errors++; $display("FAIL add_halt_pc got %h required 00000010", pc); end
    chk_drained("add");
  endtask

  task automatic test_ldsd();
    bit ok;
    int d;
    hold_reset();
    wait_cyc = 3;
    put(32'h100, 64'd12);
    put(0,  {32'h0, enc_ld(3, 32'h100, 0)});
    put(4,  {32'h0, enc_b(0, 0, 12, 3'b000)});
    put(8,  {32'h0, 32'h0000_007F});
    put(16, {32'h0, enc_sd(3, 8, 0)});
    put(20, {32'h0, enc_ld(4, 8, 0)});
    put(24, {32'h0, enc_sd(4, 32'h108, 0)});
    put(28, {32'h0, ECALL});
    exp_wr.push_back('{32'h8, 64'd12});
    exp_wr.push_back('{32'h108, 64'd12});
    release_reset();
    wait_halt(400, ok);
    chk_halt("ldsd", ok, 1'b0);
    d = find_rd(24) - find_rd(20);
    checks++;
    if (d != 11) begin errors++; $display("FAIL ld_cycles got %0d required 11", d); end
    d = find_rd(20) - find_rd(16);
    checks++;
    if (d != 10) begin errors++; $display("FAIL sd_cycles got %0d required 10", d); end
    d = find_rd(16) - find_rd(4);
    checks++;
    if (d != 6) begin errors++; $display("FAIL beq_cycles got %0d required 6", d); end
    chk_drained("ldsd");
  endtask

  task automatic test_beq();
    bit ok;
    logic [31:0] exp_seq [5];
    hold_reset();
    wait_cyc = 1;
    exp_seq[0] = 0; exp_seq[1] = 16; exp_seq[2] = 32'h100; exp_seq[3] = 20; exp_seq[4] = 24;
    put(32'h100, 64'd5);
    put(0,  {32'h0, enc_b(1, 2, 16, 3'b000)});
    put(4,  {32'h0, 32'h0000_007F});
    put(16, {32'h0, enc_ld(1, 32'h100, 0)});
    put(20, {32'h0, enc_b(1, 0, 16, 3'b000)});
    put(24, {32'h0, ECALL});
    put(36, {32'h0, 32'h0000_007F});
    release_reset();
    wait_halt(200, ok);
    chk_halt("beq", ok, 1'b0);
    checks++;
    if (pc !== 32'd24) begin errors++; $display("FAIL beq_halt_pc got %h required 00000018", pc); end
    checks++;
    if (rd_addr_log.size() != 5) begin
      errors++;
      $display("FAIL beq_reads got %0d reads required 5", rd_addr_log.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (rd_addr_log[i] !== exp_seq[i]) begin
          errors++;
          $display("FAIL beq_read%0d addr %h required %h", i, rd_addr_log[i], exp_seq[i]);
        end
      end
    end
  endtask

  task automatic test_overflow();
    bit ok;
    hold_reset();
    wait_cyc = 0;
    put(32'h100, 64'd1);
    put(32'h108, 64'hF0F3);
    put(32'h110, 64'h0E);
    put(0,  {32'h0, enc_ld(1, 32'h100, 0)});
    put(4,  {32'h0, enc_ld(2, 32'h108, 0)});
    put(8,  {32'h0, enc_ld(8, 32'h110, 0)});
    put(12, {32'h0, enc_r(7'b0100000, 1, 0, 3'b000, 5)});
    put(16, {32'h0, enc_r(7'b0000000, 1, 1, 3'b000, 0)});
    put(20, {32'h0, enc_r(7'b0000000, 8, 2, 3'b111, 6)});
    put(24, {32'h0, enc_r(7'b0000000, 8, 2, 3'b110, 7)});
    put(28, {32'h0, enc_sd(5, 32'h200, 0)});
    put(32, {32'h0, enc_sd(0, 32'h208, 0)});
    put(36, {32'h0, enc_sd(6, 32'h210, 0)});
    put(40, {32'h0, enc_sd(7, 32'h218, 0)});
    put(44, {32'h0, ECALL});
    exp_wr.push_back('{32'h200, 64'hFFFF_FFFF_FFFF_FFFF});
    exp_wr.push_back('{32'h208, 64'h0});
    exp_wr.push_back('{32'h210, 64'h2});
    exp_wr.push_back('{32'h218, 64'hF0FF});
    release_reset();
    wait_halt(300, ok);
    chk_halt("alu", ok, 1'b0);
    chk_drained("alu");
  endtask

  task automatic test_illegal();
    bit ok;
    bit req_seen;
    logic [31:0] bad [4];
    bad[0] = 32'h0000_007F;
    bad[1] = enc_r(7'b0000001, 2, 1, 3'b000, 3);
    bad[2] = enc_b(1, 2, 8, 3'b001);
    bad[3] = enc_r(7'b0000000, 2, 1, 3'b001, 3);
    for (int k = 0; k < 4; k++) begin
      hold_reset();
      wait_cyc = 0;
      put(0, {32'h0, bad[k]});
      release_reset();
      wait_halt(50, ok);
      chk_halt($sformatf("illegal%0d", k), ok, 1'b1);
      checks++;
      if (pc !== 32'h0) begin errors++; $display("FAIL illegal%0d_pc got %h required 0", k, pc); end
      req_seen = 0;
      repeat (10) begin
        @(negedge clk);
        if (mem_req) req_seen = 1;
      end
      checks++;
      if (req_seen) begin errors++; $display("FAIL illegal%0d_req got 1 in HALT required 0", k); end
    end
  endtask

  task automatic test_itype();
    bit ok;
    hold_reset();
    wait_cyc = 0;
    put(0, {32'h0, enc_i(-1, 0, 3'b000, 6, 7'b0010011)});
    put(4, {32'h0, enc_sd(6, 32'h200, 0)});
    put(8, {32'h0, ECALL});
`ifdef CPU_MC_ITYPE_EN
    exp_wr.push_back('{32'h200, 64'hFFFF_FFFF_FFFF_FFFF});
    release_reset();
    wait_halt(100, ok);
    chk_halt("addi", ok, 1'b0);
`else
    release_reset();
    wait_halt(100, ok);
    chk_halt("addi", ok, 1'b1);
    checks++;
    if (pc !== 32'h0) begin errors++; $display("FAIL addi_pc got %h required 0", pc); end
`endif
    chk_drained("addi");
  endtask

  task automatic test_reset_mid();
    bit ok;
    bit found;
    hold_reset();
    wait_cyc = 20;
    put(32'h100, 64'd5);
    put(32'h108, 64'd9);
    put(0, {32'h0, enc_ld(1, 32'h100, 0)});
    put(4, {32'h0, enc_ld(2, 32'h108, 0)});
    put(8, {32'h0, ECALL});
    release_reset();
    found = 0;
    for (int i = 0; i < 300 && !found; i++) begin
      @(negedge clk);
      found = mem_req && mem_addr == 32'h108;
    end
    checks++;
    if (!found) begin errors++; $display("FAIL midrst_pending no load request at 00000108 seen, required 1"); end
    repeat (5) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b0) begin errors++; $display("FAIL midrst_req got %b required 0", mem_req); end
    mem.delete();
    rd_addr_log.delete();
    rd_cyc_log.delete();
    wait_cyc = 0;
    put(0, {32'h0, enc_sd(1, 32'h200, 0)});
    put(4, {32'h0, enc_sd(2, 32'h208, 0)});
    put(8, {32'h0, ECALL});
    exp_wr.push_back('{32'h200, 64'h0});
    exp_wr.push_back('{32'h208, 64'h0});
    release_reset();
    wait_halt(100, ok);
    chk_halt("midrst", ok, 1'b0);
    checks++;
    if (rd_addr_log.size() == 0 || rd_addr_log[0] !== 32'h0) begin
      errors++;
      $display("FAIL midrst_fetch reads %0d first %h required fetch at 00000000", rd_addr_log.size(),
               rd_addr_log.size() > 0 ? rd_addr_log[0] : 32'hx);
    end
    chk_drained("midrst");
  endtask

  initial begin
    test_reset();
    test_add();
    test_ldsd();
    test_beq();
    test_overflow();
    test_illegal();
    test_itype();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_multicycle.md
# cpu_multicycle

Parametrised multi-cycle successor to the single-cycle core: one state machine sequences fetch, decode, execute, memory and writeback over a single shared memory port with a req/ack handshake, so memory latency is arbitrary. It executes an RV64I-style subset, with XLEN, register count, address width and reset PC configurable. It sits at the top of the CPU hierarchy, between the clock source and a unified instruction/data memory.

## Interface
- XLEN, 64: datapath and register width (32 or 64)
- NREG, 32: architectural registers (power of two, ≤32); register index fields are truncated to log2(NREG) bits
- ADDR_W, 32: memory address width, ≤ XLEN
- RESET_PC, 0: PC value loaded at reset
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- mem_req  output  1  transaction request
- mem_we  output  1  1 = store, 0 = load/fetch
- mem_addr  output  ADDR_W  byte address
- mem_wdata  output  XLEN  store data
- mem_rdata  input  XLEN  read data; fetch uses bits [31:0]
- mem_ack  input  1  transaction complete this cycle
- pc  output  ADDR_W  current instruction address
- halted  output  1  core stopped
- illegal  output  1  stop was caused by an unsupported instruction

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, HALT.
- FETCH: drive mem_req=1, mem_we=0, mem_addr=pc; on mem_ack latch mem_rdata[31:0] into IR → DECODE.
- DECODE: read rs1 = IR[19:15] and rs2 = IR[24:20] into A/B; sign-extend the immediate for the opcode's format → EXEC.
- Opcodes: 0110011 R-type; 0000011 ld; 0100011 sd; 1100011 beq (funct3 000); 1110011 ecall.
- R-type ALU ops, keyed by {funct7, funct3}: add {0000000, 000}, sub {0100000, 000}, and {0000000, 111}, or {0000000, 110}. Any other combination is illegal.
- EXEC:
  - R-type: ALUOut = A op B → WB.
  - ld/sd: ALUOut = A + imm → MEM.
  - beq: pc ← (A == B) ? pc + immB : pc + 4 → FETCH.
  - ecall → HALT.
  - Any other opcode → HALT with illegal=1.
- MEM: mem_req=1, mem_addr = ALUOut[ADDR_W-1:0], mem_we=1 for sd with mem_wdata = B.
  - sd: on ack, pc += 4 → FETCH.
  - ld: on ack, MDR ← mem_rdata → WB.
- WB: rd = IR[11:7] ← ALUOut (R-type) or MDR (ld); pc += 4 → FETCH.
- x0 reads as 0 at all times; writes to x0 are dropped.
- All arithmetic wraps modulo 2^XLEN; PC arithmetic wraps modulo 2^ADDR_W.
- HALT is terminal until reset. halted=1 in HALT; mem_req=0.

## Timing
- Reset values: pc=RESET_PC, state FETCH, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, halted=0, illegal=0. All registers in the register file clear to 0.
- Handshake:
  - mem_req, mem_we, mem_addr and mem_wdata are registered outputs, held stable while mem_req=1 until the cycle in which mem_ack=1 is sampled.
  - mem_req falls in the cycle after ack unless the next state requests again.
  - mem_ack while mem_req=0 is ignored.
  - mem_rdata is sampled only in the ack cycle.
- Cycle counts with ack on the first request cycle (W = extra wait cycles per access):
  - R-type: 4 cycles + W.
  - ld: 5 cycles + 2W.
  - sd: 4 cycles + 2W.
  - beq: 3 cycles + W.
- Every memory request holds for at least one cycle; there is no combinational path from mem_ack to mem_req.
- Reset asserted mid-transaction: mem_req drops immediately (asynchronously). The memory must discard the abandoned request. No register file write occurs.
- Register file write and read of the same register in one cycle cannot occur (WB and DECODE are distinct states).

## Configuration
- CPU_MC_ITYPE_EN defined: opcode 0010011 is supported.
  - funct3 000 = addi, 111 = andi, 110 = ori.
  - Result is ALUOut = A op immI → WB; 4 cycles + W.
- Undefined: opcode 0010011 is illegal (HALT, illegal=1).

## Structure
- Package cpu_mc_pkg holds:
  - state enum;
  - opcode constants;
  - ALU-op enum;
  - immediate-format enum.
- Sub-module cpu_mc_regfile: NREG×XLEN storage, two asynchronous read ports, one synchronous write port, x0 forced to zero, asynchronous active-low clear.
- ALU and FSM live in cpu_multicycle itself.

## Test plan
- add with zero-latency memory: x1=5, x2=7, add x3,x1,x2 (0x002081B3) → x3=12 after 4 cycles; pc 0→4.
- ld/sd with 3-cycle ack delay: sd x3,8(x0) then ld x4,8(x0) → write at mem_addr 8 with data 12; x4=12; ld takes 11 cycles.
- beq taken / not taken: x1=x2 with immB=16 → pc 0→16. Unequal operands → pc 0→4.
- Overflow and x0: sub x5,x0,x1 with x1=1 → x5=0xFFFF_FFFF_FFFF_FFFF. add x0,x1,x1 → x0 reads 0.
- Illegal and ecall:
  - Opcode 0x7F → halted=1, illegal=1, mem_req stays 0.
  - ecall → halted=1, illegal=0.
  - With CPU_MC_ITYPE_EN: addi x6,x0,-1 → x6 = all ones; without it, the same instruction → illegal=1.
- Reset during a pending load: reset asserted while mem_req=1 → mem_req=0 in the same cycle. After release, a fetch is issued at RESET_PC and all registers read 0.
